trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB, valid/allow_in handshakes).
- Accepts precise exceptions and MRET from the MEM stage and level interrupts from the platform, and updates the trap CSRs.
- Flushes the pipeline, waits for it to drain, then redirects IF to mtvec (trap) or mepc (MRET).
- Owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause, mtval, and serves the ID/EX CSR access port.

Parameters:
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec (direct mode only, bits[1:0] forced 0).
- DRAIN_TIMEOUT, 15, max DRAIN cycles before forcing redirect (4-bit counter).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- mem_inst_valid  in  1  valid instruction in MEM, not yet committed
- mem_pc  in  32  PC of that instruction
- exc_valid  in  1  MEM instruction raised a synchronous exception
- exc_cause  in  4  exception code
- exc_tval  in  32  faulting address/instruction
- mret_valid  in  1  MEM instruction is MRET
- irq_ext, irq_sw, irq_timer  in  1 each  level interrupt requests
- pipe_empty  in  1  no valid instruction in IF..MEM
- csr_we  in  1  CSR write strobe (already qualified by the CSR instruction's valid)
- csr_addr  in  12  CSR address
- csr_wdata  in  32  CSR write data
- csr_rdata  out  32  combinational read data
- flush  out  1  kill all stage valids IF..MEM
- trap_busy  out  1  state != IDLE; ID holds issue
- redirect_valid  out  1  new fetch PC available
- redirect_pc  out  32  target PC
- redirect_ready  in  1  IF accepted redirect

Behaviour:
- Reset: state IDLE; MIE=MPIE=0; mie=0; mtvec=MTVEC_RESET; mepc=mcause=mtval=0; drain counter 0; flush=trap_busy=redirect_valid=0; redirect_pc=0.
- States: IDLE, FLUSH, DRAIN, REDIRECT.
- IDLE, trap detection with mem_inst_valid=1:
  - irq_take = MIE & |(mip & mie).
  - Priority: interrupt > exc_valid > mret_valid.
- IDLE, interrupt or exception taken at edge ending cycle T:
  - mepc<=mem_pc; MPIE<=MIE; MIE<=0.
  - Interrupt: mcause={1,27'b0,code}, code priority MEI 11 > MSI 3 > MTI 7; mtval<=0.
  - Exception: mcause={1'b0,27'b0,exc_cause}; mtval<=exc_tval.
  - Target latched = {mtvec[31:2],2'b00}; state<=FLUSH.
- IDLE, MRET taken: MIE<=MPIE; MPIE<=1; target latched = mepc; state<=FLUSH.
- FLUSH: flush=1 for exactly one cycle (T+1), then state<=DRAIN.
- DRAIN: counter increments each cycle. Go to REDIRECT when pipe_empty=1 or counter==DRAIN_TIMEOUT.
- REDIRECT: redirect_valid=1 and redirect_pc=target held stable until redirect_ready=1. Then state<=IDLE and redirect_valid drops the next cycle.
- Minimum trap latency, exc_valid to redirect_valid: 3 cycles (pipe_empty already 1 in DRAIN's first cycle).
- trap_busy=1 in FLUSH/DRAIN/REDIRECT. exc_valid, mret_valid and interrupts are ignored outside IDLE.
- CSR map:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11, all other bits 0.
  - mie 0x304: bits 3/7/11 writable.
  - mtvec 0x305: bits[1:0] read 0.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342, mtval 0x343.
  - mip 0x344: read-only {irq_ext@11, irq_timer@7, irq_sw@3}.
  - Unmapped addresses read 0; writes to them are ignored.
- Same-cycle csr_we and trap/MRET capture: the trap update wins for mstatus/mepc/mcause/mtval; writes to mie/mtvec still take effect.
- A CSR write to mtvec during FLUSH/DRAIN does not change the already latched target.
- Reset asserted mid-sequence returns to IDLE next edge with all reset values; no redirect is emitted.

Decomposition:
- Shared package/defines:
  - CSR addresses.
  - Exception/interrupt cause codes.
  - mstatus bit positions.
  - State encoding (2-bit).
- One sub-module trap_csr_file:
  - Holds the CSR registers, read mux and write priority.
  - Takes capture strobes from the FSM.
  - FSM and drain counter stay in trap_ctrl.

Test Plan:
- exc_valid=1, cause=2, tval=32'h0000_0013, mem_pc=32'h0000_0040, mtvec=0x100, pipe_empty=1 -> flush at T+1; redirect_valid at T+3 with pc 0x100; mepc=0x40, mcause=2, mtval=0x13; MIE cleared.
- MIE=1, mie[7]=1, irq_timer=1, mem_inst_valid=1, mem_pc=0x80, same cycle as exc_valid -> interrupt wins; mcause=32'h8000_0007; mepc=0x80; mtval=0.
- irq_ext=irq_timer=1, both enabled -> mcause=32'h8000_000B. Same test with MIE=0 -> no trap.
- MRET with MPIE=1, mepc=0x200 -> MIE=1, MPIE=1; redirect_pc=0x200. redirect_ready held 0 for 3 cycles -> redirect_valid and pc held stable.
- pipe_empty stuck 0 -> REDIRECT entered after 15 DRAIN cycles; exc_valid pulses during DRAIN are ignored and no CSR changes.
- csr_we to mepc (0x341) in the trap-capture cycle -> mepc=mem_pc. Write 0xFFFF_FFFF to mstatus -> reads 32'h0000_1888. rst_n=0 during DRAIN -> IDLE next cycle, redirect_valid never asserted.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR map, cause codes,
// mstatus bit positions and FSM state encoding.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  // Interrupt lines / enables, one bit per machine interrupt source.
  typedef struct packed {
    logic ext;
    logic timer;
    logic sw;
  } irq_t;

  // External beats software beats timer.
  function automatic logic [3:0] irq_code(input irq_t p);
    return p.ext ? IRQ_MEI : (p.sw ? IRQ_MSI : IRQ_MTI);
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline-facing bus of the trap sequencer: MEM-stage trap requests, platform
// interrupts, the ID/EX CSR port and the IF redirect handshake.
interface trap_ctrl_if;
  logic        mem_inst_valid;
  logic [31:0] mem_pc;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        irq_ext;
  logic        irq_sw;
  logic        irq_timer;
  logic        pipe_empty;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        flush;
  logic        trap_busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  mem_inst_valid, mem_pc, exc_valid, exc_cause, exc_tval, mret_valid,
           irq_ext, irq_sw, irq_timer, pipe_empty, csr_we, csr_addr, csr_wdata,
           redirect_ready,
    output csr_rdata, flush, trap_busy, redirect_valid, redirect_pc
  );

  modport master (
    output mem_inst_valid, mem_pc, exc_valid, exc_cause, exc_tval, mret_valid,
           irq_ext, irq_sw, irq_timer, pipe_empty, csr_we, csr_addr, csr_wdata,
           redirect_ready,
    input  csr_rdata, flush, trap_busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_csr_file.sv
// Machine trap CSRs with read mux; trap/MRET capture overrides software writes
// to the registers it updates in the same cycle.
module trap_csr_file
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_cap_i,
  input  logic        mret_cap_i,
  input  logic [31:2] mem_pc_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_tval_i,
  input  irq_t        irq_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        irq_take_o,
  output logic [31:2] mtvec_o,
  output logic [31:2] mepc_o
);

  logic        mie_q, mpie_q;
  irq_t        mien_q, pend;
  logic [31:2] mtvec_q, mepc_q;
  logic [31:0] mcause_q, mtval_q;

  assign pend       = irq_i & mien_q;
  assign irq_take_o = mie_q & (|pend);
  assign mtvec_o    = mtvec_q;
  assign mepc_o     = mepc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mien_q   <= '0;
      mtvec_q  <= MTVEC_RESET[31:2];
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      if (csr_we_i) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            mie_q  <= csr_wdata_i[MSTATUS_MIE];
            mpie_q <= csr_wdata_i[MSTATUS_MPIE];
          end
          CSR_MIE:    mien_q   <= {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
          CSR_MTVEC:  mtvec_q  <= csr_wdata_i[31:2];
          CSR_MEPC:   mepc_q   <= csr_wdata_i[31:2];
          CSR_MCAUSE: mcause_q <= csr_wdata_i;
          CSR_MTVAL:  mtval_q  <= csr_wdata_i;
          default: ;
        endcase
      end
      // Later assignments win: capture takes priority over a same-cycle write.
      if (trap_cap_i) begin
        mepc_q <= mem_pc_i;
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
        if (irq_take_o) begin
          mcause_q <= {1'b1, 27'b0, irq_code(pend)};
          mtval_q  <= '0;
        end else begin
          mcause_q <= {28'b0, exc_cause_i};
          mtval_q  <= exc_tval_i;
        end
      end else if (mret_cap_i) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[12:11]        = 2'b11;
        csr_rdata_o[MSTATUS_MPIE] = mpie_q;
        csr_rdata_o[MSTATUS_MIE]  = mie_q;
      end
      CSR_MIE: begin
        csr_rdata_o[11] = mien_q.ext;
        csr_rdata_o[7]  = mien_q.timer;
        csr_rdata_o[3]  = mien_q.sw;
      end
      CSR_MIP: begin
        csr_rdata_o[11] = irq_i.ext;
        csr_rdata_o[7]  = irq_i.timer;
        csr_rdata_o[3]  = irq_i.sw;
      end
      CSR_MTVEC:  csr_rdata_o = {mtvec_q, 2'b00};
      CSR_MEPC:   csr_rdata_o = {mepc_q, 2'b00};
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MTVAL:  csr_rdata_o = mtval_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: capture trap/MRET from MEM, flush, drain the
// pipeline (bounded), then redirect IF to mtvec or mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0100,
  parameter int          DRAIN_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  trap_ctrl_if.slave  bus
);

  localparam logic [3:0] TIMEOUT = 4'(DRAIN_TIMEOUT);

  state_e      state_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_q, busy_q, rv_q;
  logic [31:0] rpc_q;

  logic        irq_take, take, trap_cap, mret_cap;
  logic [31:2] mtvec, mepc;

  assign take     = (state_q == ST_IDLE) && bus.mem_inst_valid;
  assign trap_cap = take && (irq_take || bus.exc_valid);
  assign mret_cap = take && !irq_take && !bus.exc_valid && bus.mret_valid;

  trap_csr_file #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
    .clk         (clk),
    .rst_n       (rst_n),
    .trap_cap_i  (trap_cap),
    .mret_cap_i  (mret_cap),
    .mem_pc_i    (bus.mem_pc[31:2]),
    .exc_cause_i (bus.exc_cause),
    .exc_tval_i  (bus.exc_tval),
    .irq_i       ({bus.irq_ext, bus.irq_timer, bus.irq_sw}),
    .csr_we_i    (bus.csr_we),
    .csr_addr_i  (bus.csr_addr),
    .csr_wdata_i (bus.csr_wdata),
    .csr_rdata_o (bus.csr_rdata),
    .irq_take_o  (irq_take),
    .mtvec_o     (mtvec),
    .mepc_o      (mepc)
  );

  // cnt_d is the number of DRAIN cycles completed at the end of this one.
  assign cnt_d = cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trap_cap || mret_cap) begin
            state_q <= ST_FLUSH;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
            // Target is frozen here so later mtvec/mepc writes cannot move it.
            rpc_q   <= {trap_cap ? mtvec : mepc, 2'b00};
          end
        end
        ST_FLUSH: begin
          state_q <= ST_DRAIN;
          flush_q <= 1'b0;
          cnt_q   <= '0;
        end
        ST_DRAIN: begin
          cnt_q <= cnt_d;
          if (bus.pipe_empty || cnt_d == TIMEOUT) begin
            state_q <= ST_REDIRECT;
            rv_q    <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            state_q <= ST_IDLE;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.flush          = flush_q;
  assign bus.trap_busy      = busy_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized scoreboard bench for trap_ctrl against a CSR-level reference model.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_ctrl_if bus();
  trap_ctrl #(.MTVEC_RESET(32'h0000_0100), .DRAIN_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Reference model: architectural CSR state only. irq vectors are {ext,timer,sw}.
  logic        m_mie, m_mpie;
  logic [2:0]  m_en;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;

  typedef struct {
    logic mv, ex, mr;
    logic [2:0] irq;
    logic [3:0] cause;
    logic [31:0] tval, pc, wdata;
    int pe_at, rdy_wait, rst_at;
    logic noise, wr_tvec, cap_we;
  } ev_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0; m_en = 0;
    m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
      12'h304: m_en = {d[11], d[7], d[3]};
      12'h305: m_mtvec = d & ~32'h3;
      12'h341: m_mepc = d & ~32'h3;
      12'h342: m_mcause = d;
      12'h343: m_mtval = d;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, input logic [2:0] irq);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return (32'(m_en[2]) << 11) | (32'(m_en[1]) << 7) | (32'(m_en[0]) << 3);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (32'(irq[2]) << 11) | (32'(irq[1]) << 7) | (32'(irq[0]) << 3);
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.mem_inst_valid = 0; bus.exc_valid = 0; bus.mret_valid = 0;
    bus.irq_ext = 0; bus.irq_timer = 0; bus.irq_sw = 0; bus.csr_we = 0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we = 1; bus.csr_addr = a; bus.csr_wdata = d;
    model_write(a, d);
    step();
    bus.csr_we = 0;
  endtask

  task automatic check_csrs();
    logic [11:0] addrs[8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
    string names[8] = '{"mstatus", "mie", "mtvec", "mepc", "mcause", "mtval", "mip", "unmapped"};
    logic [2:0] r = 3'($urandom);
    {bus.irq_ext, bus.irq_timer, bus.irq_sw} = r;
    for (int i = 0; i < 8; i++) begin
      bus.csr_addr = addrs[i];
      #1;
      chk(names[i], bus.csr_rdata, model_read(addrs[i], r));
    end
    idle_inputs();
    step();
  endtask

  function automatic ev_t mk(input logic mv, ex, mr, input logic [2:0] irq, input logic [3:0] cause,
                             input logic [31:0] tval, pc, input int pe_at);
    ev_t e;
    e.mv = mv; e.ex = ex; e.mr = mr; e.irq = irq; e.cause = cause; e.tval = tval; e.pc = pc;
    e.pe_at = pe_at; e.rdy_wait = 0; e.rst_at = 0; e.noise = 0; e.wr_tvec = 0; e.cap_we = 0;
    e.wdata = 0;
    return e;
  endfunction

  // One MEM-stage event from IDLE; the scoreboard gets the expected redirect target.
  task automatic run_event(input ev_t e);
    logic [2:0] pend;
    logic irq_take, exc_take, mret_take, taken;
    logic [31:0] tgt;
    int d;
    pend = e.irq & m_en;
    irq_take  = e.mv && m_mie && (pend != 0);
    exc_take  = e.mv && e.ex && !irq_take;
    mret_take = e.mv && e.mr && !e.ex && !irq_take;
    taken = irq_take || exc_take || mret_take;
    d = (e.pe_at < 15) ? e.pe_at : 15;
    tgt = 0;

    bus.mem_inst_valid = e.mv; bus.mem_pc = e.pc; bus.exc_valid = e.ex;
    bus.exc_cause = e.cause; bus.exc_tval = e.tval; bus.mret_valid = e.mr;
    {bus.irq_ext, bus.irq_timer, bus.irq_sw} = e.irq;
    if (e.cap_we) begin
      bus.csr_we = 1; bus.csr_addr = CSR_MEPC; bus.csr_wdata = e.wdata;
      model_write(CSR_MEPC, e.wdata);
    end
    if (irq_take || exc_take) begin
      tgt = m_mtvec;
      m_mepc = e.pc & ~32'h3; m_mpie = m_mie; m_mie = 0;
      if (irq_take) begin
        m_mcause = 32'h8000_0000 | (pend[2] ? 32'd11 : (pend[0] ? 32'd3 : 32'd7));
        m_mtval = 0;
      end else begin
        m_mcause = {28'b0, e.cause}; m_mtval = e.tval;
      end
    end else if (mret_take) begin
      tgt = m_mepc; m_mie = m_mpie; m_mpie = 1;
    end
    step();
    idle_inputs();
    bus.pipe_empty = 0;
    @(negedge clk);
    chk("flush", 32'(bus.flush), 32'(taken));
    chk("busy", 32'(bus.trap_busy), 32'(taken));
    if (!taken) begin
      step();
      @(negedge clk);
      chk("idle_flush", 32'(bus.flush), 0);
      chk("idle_busy", 32'(bus.trap_busy), 0);
      step();
      return;
    end
    if (e.rst_at == 0) exp_q.push_back(tgt);
    for (int k = 1; k <= d; k++) begin
      step();
      idle_inputs();
      bus.pipe_empty = (k >= e.pe_at);
      if (e.noise) begin
        bus.mem_inst_valid = 1'($urandom); bus.exc_valid = 1'($urandom);
        bus.mret_valid = 1'($urandom); bus.exc_cause = 4'($urandom);
        bus.mem_pc = $urandom; bus.exc_tval = $urandom;
      end
      if (k == 1 && e.wr_tvec) begin
        bus.csr_we = 1; bus.csr_addr = CSR_MTVEC; bus.csr_wdata = e.wdata;
        model_write(CSR_MTVEC, e.wdata);
      end
      if (k == e.rst_at) rst_n = 0;
      @(negedge clk);
      chk("drain_rv", 32'(bus.redirect_valid), 0);
      chk("drain_flush", 32'(bus.flush), 0);
      chk("drain_busy", 32'(bus.trap_busy), 1);
      if (k == e.rst_at) begin
        step();
        rst_n = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        chk("rst_rv", 32'(bus.redirect_valid), 0);
        chk("rst_busy", 32'(bus.trap_busy), 0);
        chk("rst_flush", 32'(bus.flush), 0);
        step();
        return;
      end
    end
    step();
    idle_inputs();
    bus.pipe_empty = 1;
    for (int w = 0; w <= e.rdy_wait; w++) begin
      bus.redirect_ready = (w == e.rdy_wait);
      @(negedge clk);
      chk("redir_rv", 32'(bus.redirect_valid), 1);
      chk("redir_busy", 32'(bus.trap_busy), 1);
      step();
    end
    bus.redirect_ready = 0;
    @(negedge clk);
    chk("redir_drop", 32'(bus.redirect_valid), 0);
    chk("busy_drop", 32'(bus.trap_busy), 0);
    step();
  endtask

  // Monitor: every presented redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (bus.redirect_valid) begin
      if (exp_q.size() == 0) chk("redir_unexp", 32'(bus.redirect_valid), 0);
      else begin
        chk("redir_pc", bus.redirect_pc, exp_q[0]);
        if (bus.redirect_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    ev_t e;
    idle_inputs();
    bus.mem_pc = 0; bus.exc_cause = 0; bus.exc_tval = 0; bus.pipe_empty = 1;
    bus.csr_addr = 0; bus.csr_wdata = 0; bus.redirect_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_flush0", 32'(bus.flush), 0);
    chk("rst_busy0", 32'(bus.trap_busy), 0);
    chk("rst_rv0", 32'(bus.redirect_valid), 0);
    chk("rst_pc0", bus.redirect_pc, 0);
    step();
    check_csrs();

    e = mk(1, 1, 0, 3'b000, 4'd2, 32'h13, 32'h40, 1); run_event(e); check_csrs();

    csr_write(CSR_MSTATUS, 32'h8); csr_write(CSR_MIE, 32'h80);
    e = mk(1, 1, 0, 3'b010, 4'd5, 32'hABC, 32'h80, 1); run_event(e); check_csrs();

    csr_write(CSR_MSTATUS, 32'h8); csr_write(CSR_MIE, 32'h880);
    e = mk(1, 0, 0, 3'b110, 4'd0, 32'h0, 32'h90, 2); run_event(e); check_csrs();

    csr_write(CSR_MSTATUS, 32'h0);
    e = mk(1, 0, 0, 3'b110, 4'd0, 32'h0, 32'h94, 1); run_event(e); check_csrs();

    csr_write(CSR_MSTATUS, 32'h80); csr_write(CSR_MEPC, 32'h200);
    e = mk(1, 0, 1, 3'b000, 4'd0, 32'h0, 32'h44, 1); e.rdy_wait = 3; run_event(e); check_csrs();

    e = mk(1, 1, 0, 3'b000, 4'd4, 32'h1234, 32'h60, 99);
    e.noise = 1; e.wr_tvec = 1; e.wdata = 32'h300; run_event(e); check_csrs();

    e = mk(1, 1, 0, 3'b000, 4'd6, 32'h8, 32'h70, 1);
    e.cap_we = 1; e.wdata = 32'hDEAD_BEE0; run_event(e); check_csrs();

    csr_write(CSR_MSTATUS, 32'hFFFF_FFFF); check_csrs();

    e = mk(1, 1, 0, 3'b000, 4'd2, 32'h0, 32'h50, 99); e.rst_at = 5; run_event(e); check_csrs();

    for (int n = 0; n < 60; n++) begin
      if ($urandom % 2 == 0) csr_write(CSR_MSTATUS, $urandom);
      if ($urandom % 3 == 0) csr_write(CSR_MIE, $urandom);
      if ($urandom % 4 == 0) csr_write(CSR_MTVEC, $urandom);
      if ($urandom % 4 == 0) csr_write(CSR_MEPC, $urandom);
      if ($urandom % 8 == 0) csr_write(12'($urandom), $urandom);
      e = mk(($urandom % 6) != 0, 1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom),
             $urandom, $urandom, int'($urandom_range(1, 20)));
      e.rdy_wait = int'($urandom % 4);
      if ($urandom % 12 == 0) e.rst_at = int'($urandom_range(1, (e.pe_at < 15) ? e.pe_at : 15));
      e.noise = ($urandom % 3 == 0);
      e.wr_tvec = ($urandom % 4 == 0);
      e.cap_we = !e.mr && ($urandom % 4 == 0);
      e.wdata = $urandom;
      run_event(e);
      check_csrs();
    end

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
